// File: rtl/imem_fetch_unit.sv
// rtl/imem_fetch_unit.sv - instruction fetch unit with prefetch FIFO and redirect
module imem_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [31:0] o_instr_addr,
    output logic        o_instr_read,
    output logic        o_instr_write,
    output logic [3:0]  o_instr_size,
    output logic [31:0] o_instr_wr_data,
    input  logic [31:0] i_instr_rd_data,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    input  logic        i_ready
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_V = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

    logic [31:0] buf_pc    [FIFO_DEPTH];
    logic [31:0] buf_instr [FIFO_DEPTH];

    logic        pop, push, issue;
    logic [31:0] redirect_addr;
    logic [CW:0] occupancy;

    assign redirect_addr   = i_redirect_pc & 32'hFFFF_FFFC;
    assign o_valid         = (count_q != '0);
    assign pop             = o_valid && i_ready;
    assign push            = inflight_q && !i_redirect;

    // Slots already committed (buffered + in flight) after this cycle's pop.
    assign occupancy = {1'b0, count_q} + (CW + 1)'(inflight_q) - (CW + 1)'(pop);
    assign issue     = i_rst_n && (i_redirect || (occupancy < DEPTH_V));

    assign o_instr_read    = issue;
    assign o_instr_addr    = i_redirect ? redirect_addr : pc_q;
    assign o_instr_write   = 1'b0;
    assign o_instr_size    = 4'b1111;
    assign o_instr_wr_data = 32'h0000_0000;

    assign o_instr = o_valid ? buf_instr[rd_ptr_q] : 32'h0000_0000;
    assign o_pc    = o_valid ? buf_pc[rd_ptr_q]    : 32'h0000_0000;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = o_instr_addr;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        if (i_redirect) begin
            // Stale buffered words and the outstanding response are dropped.
            pc_d     = redirect_addr + 32'd4;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (issue) begin
                pc_d = pc_q + 32'd4;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q          <= {RESET_PC[31:2], 2'b00};
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0000_0000;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            buf_pc[wr_ptr_q]    <= inflight_pc_q;
            buf_instr[wr_ptr_q] <= i_instr_rd_data;
        end
    end
endmodule
